tlut_simd_engine: RTL



---
 rtl/tlut_pkg.sv | 28 ++
 rtl/tlut_simd_engine_adder_tree.sv | 37 +++
 rtl/tlut_simd_engine.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/tlut_pkg.sv
// tlut_pkg: shared types and width helpers for the temporal-LUT SIMD engine.
// Holds the FSM state enum, width functions and the max helper.
package tlut_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } tlut_state_e;

    // Width of the reduced weight sum.
    function automatic int wsum_w(input int ww, input int dc);
        return ww + $clog2(dc);
    endfunction

    // Minimum signed product width.
    function automatic int acc_w(input int ww, input int iw, input int dc);
        return ww + iw + $clog2(dc);
    endfunction

    // Pairwise unsigned maximum used by the early-termination reduction.
    function automatic int unsigned max_val(input int unsigned a,
                                           input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tlut_simd_engine_adder_tree.sv
// tlut_adder_tree: combinational signed reduction of N values of W bits.
// Odd element counts at any level pass the last element through.
module tlut_adder_tree #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic [N-1:0][W-1:0]          in_i,
    output logic signed [W+$clog2(N)-1:0] sum_o
);

    localparam int OW = W + $clog2(N);
    localparam int LV = $clog2(N);

    function automatic int lvl_cnt(input int l);
        return (N + (1 << l) - 1) >> l;
    endfunction

    for (genvar l = 0; l <= LV; l++) begin : g_lv
        localparam int C = lvl_cnt(l);
        logic signed [OW-1:0] v [C];
        for (genvar i = 0; i < C; i++) begin : g_n
            if (l == 0) begin : g_leaf
                assign v[i] = OW'(signed'(in_i[i]));
            end else begin : g_node
                localparam int P = lvl_cnt(l - 1);
                if (2 * i + 1 < P) begin : g_add
                    assign v[i] = g_lv[l-1].v[2*i] + g_lv[l-1].v[2*i+1];
                end else begin : g_pass
                    assign v[i] = g_lv[l-1].v[2*i];
                end
            end
        end
    end

    assign sum_o = g_lv[LV].v[0];

endmodule

// File: rtl/tlut_simd_engine.sv
// tlut_simd_engine: temporal-LUT SIMD multiply with valid/ready handshakes.
// Optional early termination enabled by defining TLUT_EARLY_TERM_EN.
module tlut_simd_engine
    import tlut_pkg::*;
#(
    parameter int DIM_A        = 4,
    parameter int DIM_C        = 4,
    parameter int INPUT_WIDTH  = 4,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = acc_w(WEIGHT_WIDTH, INPUT_WIDTH, DIM_C)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  enable,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [DIM_A-1:0][INPUT_WIDTH-1:0]     input_bin,
    input  logic [DIM_C-1:0][WEIGHT_WIDTH-1:0]    weight_bin,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DIM_A-1:0][ACC_WIDTH-1:0]       product_out,
    output logic                                  busy
);

    localparam int WSW = wsum_w(WEIGHT_WIDTH, DIM_C);

    if (ACC_WIDTH < acc_w(WEIGHT_WIDTH, INPUT_WIDTH, DIM_C)) begin : g_bad_acc
        $error("ACC_WIDTH too small for the product range");
    end

    tlut_state_e                        state_q, state_d;
    logic [DIM_A-1:0][INPUT_WIDTH-1:0]  in_q, in_d;
    logic [DIM_C-1:0][WEIGHT_WIDTH-1:0] w_q, w_d;
    logic signed [WSW-1:0]              wsum_q, wsum_d, tree_sum;
    logic [INPUT_WIDTH-1:0]             cnt_q, cnt_d, kend;
    logic signed [ACC_WIDTH-1:0]        acc_q, acc_d;
    logic [DIM_A-1:0][ACC_WIDTH-1:0]    prod_q, prod_d;
    logic                               accept;

    tlut_adder_tree #(
        .N(DIM_C),
        .W(WEIGHT_WIDTH)
    ) u_tree (
        .in_i (w_q),
        .sum_o(tree_sum)
    );

`ifdef TLUT_EARLY_TERM_EN
    logic [INPUT_WIDTH-1:0] kend_q, kend_d, in_max;

    // Largest activation: the sweep can stop once it has been captured.
    always_comb begin
        int unsigned mx;
        mx = 0;
        for (int a = 0; a < DIM_A; a++) begin
            mx = max_val(mx, 32'(in_q[a]));
        end
        in_max = INPUT_WIDTH'(mx);
    end

    // Sweep end point register, loaded alongside wsum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kend_q <= '0;
        end else begin
            kend_q <= kend_d;
        end
    end

    assign kend_d = (state_q == LOAD) ? in_max : kend_q;
    assign kend   = kend_q;
`else
    assign kend = '1;
`endif

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d  = state_q;
        in_d     = in_q;
        w_d      = w_q;
        wsum_d   = wsum_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        prod_d   = prod_q;
        in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        accept   = in_valid && in_ready;

        unique case (state_q)
            IDLE: ;
            LOAD: begin
                wsum_d  = tree_sum;
                cnt_d   = '0;
                acc_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                if (enable) begin
                    for (int a = 0; a < DIM_A; a++) begin
                        if (in_q[a] == cnt_q) begin
                            prod_d[a] = acc_q;
                        end
                    end
                    acc_d = acc_q + ACC_WIDTH'(wsum_q);
                    cnt_d = cnt_q + INPUT_WIDTH'(1);
                    if (cnt_q == kend) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            in_d    = input_bin;
            w_d     = weight_bin;
            state_d = LOAD;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            in_q    <= '0;
            w_q     <= '0;
            wsum_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            in_q    <= in_d;
            w_q     <= w_d;
            wsum_q  <= wsum_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
        end
    end

    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign product_out = prod_q;

endmodule
